// File: rtl/instr_mem_bank.sv
// Instruction memory for the fetch stage: clear sweep after reset, streaming loader, registered stall-aware fetch.
// Optional fetch counter output enabled by defining IMEM_FETCH_CNT_EN.
module instr_mem_bank #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH      = 64,
  parameter int unsigned       PC_W       = 32,
  parameter logic [DATA_W-1:0] RESET_WORD = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic              fetch_stall,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault
`ifdef IMEM_FETCH_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  logic [1:0]        state, state_next;
  logic [AW-1:0]     ptr, ptr_next;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              done_next;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              fetch_accept;
  logic              pc_fault;
  logic [AW-1:0]     pc_idx;

  // State register plus registered status outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      ptr        <= '0;
      load_done  <= 1'b0;
      busy       <= 1'b1;
      load_ready <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      load_done  <= done_next;
      busy       <= (state_next != ST_IDLE);
      load_ready <= (state_next == ST_LOAD);
    end
  end

  // Next-state and write-port control
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    mem_we     = 1'b0;
    mem_wdata  = RESET_WORD;
    done_next  = 1'b0;
    case (state)
      ST_CLEAR: begin
        mem_we   = 1'b1;
        ptr_next = ptr + AW'(1);
        if (ptr == AW'(DEPTH - 1)) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (load_start) begin
          state_next = ST_LOAD;
          ptr_next   = '0;
        end
      end
      ST_LOAD: begin
        // A restart pulse wins over a word offered in the same cycle
        if (load_start) begin
          ptr_next = '0;
        end else if (load_valid) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
          ptr_next  = ptr + AW'(1);
          if (load_last || (ptr == AW'(DEPTH - 1))) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  // Storage array; no reset, the clear sweep initialises it
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[ptr] <= mem_wdata;
  end

  assign fetch_ready  = (state == ST_IDLE) && !load_start && !(fetch_valid && fetch_stall);
  assign fetch_accept = fetch_req && fetch_ready;
  assign pc_idx       = fetch_pc[AW+1:2];
  assign pc_fault     = (fetch_pc[1:0] != 2'b00) || (fetch_pc[PC_W-1:AW+2] != '0);

  // Registered fetch response, held while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_instr <= RESET_WORD;
      fetch_fault <= 1'b0;
    end else if (fetch_accept) begin
      fetch_valid <= 1'b1;
      fetch_fault <= pc_fault;
      fetch_instr <= pc_fault ? RESET_WORD : mem[pc_idx];
    end else if (!(fetch_valid && fetch_stall)) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end
  end

`ifdef IMEM_FETCH_CNT_EN
  // Saturating count of accepted fetches, survives reloads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (fetch_accept && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_bank.sv
// Directed self-checking bench for instr_mem_bank (default parameters).
module tb_instr_mem_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready, load_done, busy;
  logic        fetch_req, fetch_stall;
  logic [31:0] fetch_pc;
  logic        fetch_ready, fetch_valid, fetch_fault;
  logic [31:0] fetch_instr;
`ifdef IMEM_FETCH_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] cnt_before;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_mem_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .busy        (busy),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_stall (fetch_stall),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault)
`ifdef IMEM_FETCH_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Counts busy-high samples from the release point until busy drops
  task automatic release_and_count(input string tag);
    int cnt;
    cnt = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk);
    end
    check(tag, 32'(cnt), 32'd64);
  endtask

  // Single fetch issued at a negedge; response checked one cycle later
  task automatic do_fetch(input string tag, input logic [31:0] pc,
                          input logic [31:0] exp_instr, input logic exp_fault);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    #1;
    check({tag, "_ready"}, 32'(fetch_ready), 32'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    check({tag, "_instr"}, fetch_instr, exp_instr);
    check({tag, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
  endtask

  initial begin
    int done_cnt;
    logic [31:0] words [3];
    words[0] = 32'h0050_0093;
    words[1] = 32'h00A0_0113;
    words[2] = 32'h0020_81B3;

    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; fetch_req = 1'b0; fetch_stall = 1'b0; fetch_pc = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_instr", fetch_instr, 32'h0000_0013);
    check("rst_fault", 32'(fetch_fault), 32'd0);

    release_and_count("clear_cycles");
    do_fetch("nop_0", 32'h0, 32'h0000_0013, 1'b0);
    do_fetch("nop_10", 32'h10, 32'h0000_0013, 1'b0);
    do_fetch("nop_fc", 32'hFC, 32'h0000_0013, 1'b0);

    // Three-word burst
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("load_ready", 32'(load_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == 2);
      @(negedge clk);
    end
    load_valid = 1'b0; load_last = 1'b0;
    done_cnt = 0;
    repeat (5) begin
      if (load_done) done_cnt++;
      @(negedge clk);
    end
    check("load_done_pulses", 32'(done_cnt), 32'd1);
    check("post_load_busy", 32'(busy), 32'd0);
    check("post_load_ready", 32'(load_ready), 32'd0);
    do_fetch("ld_4", 32'h4, 32'h00A0_0113, 1'b0);
    do_fetch("ld_c", 32'hC, 32'h0000_0013, 1'b0);

    // Back-to-back fetches
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'(i * 4);
      @(negedge clk);
      check("b2b_valid", 32'(fetch_valid), 32'd1);
      check("b2b_instr", fetch_instr, words[i]);
    end
    fetch_req = 1'b0;
    @(negedge clk);
    check("b2b_drop", 32'(fetch_valid), 32'd0);

    // Stall holds the response and blocks acceptance
    fetch_req = 1'b1;
    fetch_pc  = 32'h4;
    @(negedge clk);
    fetch_stall = 1'b1;
    fetch_pc    = 32'h8;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", 32'(fetch_ready), 32'd0);
      check("stall_valid", 32'(fetch_valid), 32'd1);
      check("stall_instr", fetch_instr, 32'h00A0_0113);
      @(negedge clk);
    end
    fetch_stall = 1'b0;
    #1;
    check("unstall_ready", 32'(fetch_ready), 32'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    check("unstall_valid", 32'(fetch_valid), 32'd1);
    check("unstall_instr", fetch_instr, 32'h0020_81B3);

    // Faulting fetches
`ifdef IMEM_FETCH_CNT_EN
    cnt_before = fetch_count;
`endif
    do_fetch("flt_mis", 32'h6, 32'h0000_0013, 1'b1);
    do_fetch("flt_oor", 32'h100, 32'h0000_0013, 1'b1);
`ifdef IMEM_FETCH_CNT_EN
    check("fetch_count_delta", fetch_count - cnt_before, 32'd2);
`endif

    // load_start beats a same-cycle fetch request
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_pc   = 32'h0;
    #1;
    check("coll_ready", 32'(fetch_ready), 32'd0);
    @(negedge clk);
    load_start = 1'b0;
    fetch_req  = 1'b0;
    check("coll_no_resp", 32'(fetch_valid), 32'd0);
    check("coll_in_load", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    load_valid = 1'b0;

    // Reset mid-load discards partial contents and re-runs the clear
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_load_ready", 32'(load_ready), 32'd0);
    release_and_count("reclear_cycles");
    do_fetch("reclear_0", 32'h0, 32'h0000_0013, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
